// File: rtl/seg_msg_sched.sv
// Display message scheduler: arbitrates err/wr/rd one-digit messages onto the
// seven-segment driver with a fixed hold time, a dash gap and error pre-emption.
module seg_msg_sched #(
  parameter int unsigned HOLD_CYCLES  = 100000000,
  parameter int unsigned BLANK_CYCLES = 10000000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       err_req,
  input  logic [3:0] err_code,
  output logic       err_ack,
  input  logic       wr_req,
  input  logic [3:0] wr_digit,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [3:0] rd_digit,
  output logic       rd_ack,
  input  logic       init_done,
  output logic [3:0] digit,
  output logic       show_digit,
  output logic       init_ok,
  output logic       error_flag,
  output logic [1:0] active_src,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]       SrcNone   = 2'd0;
  localparam logic [1:0]       SrcRd     = 2'd1;
  localparam logic [1:0]       SrcWr     = 2'd2;
  localparam logic [1:0]       SrcErr    = 2'd3;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_err_q, pend_err_d, pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [3:0]       err_data_q, err_data_d, wr_data_q, wr_data_d, rd_data_q, rd_data_d;
  logic [3:0]       digit_q, digit_d;
  logic [1:0]       src_q, src_d;
  logic             err_ack_q, err_ack_d, wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic             error_flag_q, error_flag_d;
  logic             init_q;
  logic             take_err, take_wr, take_rd;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    src_d        = src_q;
    err_ack_d    = 1'b0;
    wr_ack_d     = 1'b0;
    rd_ack_d     = 1'b0;
    error_flag_d = error_flag_q;
    take_err     = 1'b0;
    take_wr      = 1'b0;
    take_rd      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_err_q)     take_err = 1'b1;
        else if (pend_wr_q) take_wr  = 1'b1;
        else if (pend_rd_q) take_rd  = 1'b1;
      end
      StShow: begin
        // An error already on display is never displaced by another error.
        if (pend_err_q && src_q != SrcErr) begin
          take_err = 1'b1;
        end else if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          src_d   = SrcNone;
          state_d = (BLANK_CYCLES == 0) ? StIdle : StBlank;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StBlank: begin
        if (pend_err_q) begin
          take_err = 1'b1;
        end else if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (take_err || take_wr || take_rd) begin
      state_d = StShow;
      cnt_d   = '0;
    end
    if (take_err) begin
      digit_d      = err_data_q;
      src_d        = SrcErr;
      err_ack_d    = 1'b1;
      error_flag_d = 1'b1;
    end else if (take_wr) begin
      digit_d  = wr_data_q;
      src_d    = SrcWr;
      wr_ack_d = 1'b1;
    end else if (take_rd) begin
      digit_d  = rd_data_q;
      src_d    = SrcRd;
      rd_ack_d = 1'b1;
    end
  end

  // A request coinciding with its own consumption keeps the flag set.
  always_comb begin
    pend_err_d = err_req | (pend_err_q & ~take_err);
    pend_wr_d  = wr_req  | (pend_wr_q  & ~take_wr);
    pend_rd_d  = rd_req  | (pend_rd_q  & ~take_rd);
    err_data_d = err_req ? err_code : err_data_q;
    wr_data_d  = wr_req  ? wr_digit : wr_data_q;
    rd_data_d  = rd_req  ? rd_digit : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pend_err_q   <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_rd_q    <= 1'b0;
      err_data_q   <= '0;
      wr_data_q    <= '0;
      rd_data_q    <= '0;
      digit_q      <= '0;
      src_q        <= SrcNone;
      err_ack_q    <= 1'b0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      error_flag_q <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_err_q   <= pend_err_d;
      pend_wr_q    <= pend_wr_d;
      pend_rd_q    <= pend_rd_d;
      err_data_q   <= err_data_d;
      wr_data_q    <= wr_data_d;
      rd_data_q    <= rd_data_d;
      digit_q      <= digit_d;
      src_q        <= src_d;
      err_ack_q    <= err_ack_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      error_flag_q <= error_flag_d;
      init_q       <= init_done;
    end
  end

  assign digit      = digit_q;
  assign show_digit = (state_q == StShow);
  assign active_src = src_q;
  assign busy       = (state_q != StIdle);
  assign error_flag = error_flag_q;
  assign init_ok    = init_q & ~error_flag_q;
  assign err_ack    = err_ack_q;
  assign wr_ack     = wr_ack_q;
  assign rd_ack     = rd_ack_q;

endmodule

// File: doc/seg_msg_sched.md
Name: seg_msg_sched

Overview:
- Arbitrates and sequences the messages shown on the 8-digit seven-segment display.
- Three requesters share the display: SD error reporting, write-confirm and read-back digit. Each posts a one-digit message.
- The block shows each message for a fixed hold time, separates messages with a blank gap, and lets errors pre-empt anything else.
- Its outputs drive the seven_seg driver's digit, show_digit, init_ok and error_flag inputs directly.

Parameters:
- HOLD_CYCLES, 100000000: cycles a message stays displayed (1 s at 100 MHz); must be >= 1.
- BLANK_CYCLES, 10000000: dash gap between messages; 0 skips the gap.
- CNT_W, 27: counter width; must hold max(HOLD_CYCLES, BLANK_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- err_req  in  1  single-cycle pulse: post error code.
- err_code  in  4  error code, sampled with err_req.
- err_ack  out  1  one-cycle pulse: error message started displaying.
- wr_req  in  1  pulse: post write-confirm digit.
- wr_digit  in  4  digit, sampled with wr_req.
- wr_ack  out  1  pulse: write message started.
- rd_req  in  1  pulse: post read-back digit.
- rd_digit  in  4  digit, sampled with rd_req.
- rd_ack  out  1  pulse: read message started.
- init_done  in  1  level: SD card initialised.
- digit  out  4  value to display.
- show_digit  out  1  1 = show digit, 0 = dashes.
- init_ok  out  1  status to driver.
- error_flag  out  1  sticky error status to driver.
- active_src  out  2  source being shown: 0 none, 1 rd, 2 wr, 3 err.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, digit=0, state IDLE, counter 0, all pending flags and data cleared.
- Capture: each source has a pending flag plus a 4-bit data register.
  - A req pulse sets the flag and loads the data at that clock edge.
  - A new req while the flag is already set overwrites the data (latest wins). No extra ack is generated.
  - A req arriving in the same cycle as its own flag is consumed leaves the flag set, holding the new data.
- Priority: err > wr > rd, fixed.
- IDLE:
  - No pending flag: show_digit=0, active_src=0.
  - Else pick the highest-priority pending source. At the next edge: clear its flag, load digit, set active_src, pulse that source's ack, counter=0, go to SHOW.
- Latency: req sampled at edge E. Pending is set after E. Ack, show_digit=1 and digit are valid in the cycle after edge E+1, i.e. 2 cycles request-to-display.
- SHOW:
  - show_digit=1. Stays exactly HOLD_CYCLES cycles.
  - On expiry go to BLANK, or to IDLE if BLANK_CYCLES=0.
  - show_digit and active_src go to 0 on leaving SHOW.
- BLANK: show_digit=0, active_src=0. Stays exactly BLANK_CYCLES cycles, then IDLE.
- Error pre-emption:
  - err pending during SHOW of rd/wr, or during BLANK: next edge loads the error directly. Sequence: err_ack pulse, SHOW restarted, counter=0, no blank.
  - The displaced message is dropped, not re-queued.
  - An error already in SHOW is never pre-empted. A new err_req only sets pending and waits.
- Non-error requests arriving in SHOW or BLANK wait in pending. No pre-emption among rd and wr.
- error_flag: set on the edge that enters SHOW with the err source. Stays set until rst.
- init_ok: init_done registered one cycle, gated by ~error_flag.
- Ack pulses are exactly one cycle, and at most one ack is high per cycle.
- Counter:
  - Increments in SHOW and BLANK.
  - Compares against HOLD_CYCLES-1 and BLANK_CYCLES-1.
  - Resets to 0 on every state entry. No wrap beyond the limit.
- rst mid-message: the next cycle shows all reset values. Pending requests are lost, and no ack is issued for them.

Test Plan (HOLD_CYCLES=8, BLANK_CYCLES=2):
- Reset, then rd_req with rd_digit=5 -> 2 cycles later rd_ack=1 for 1 cycle, digit=5, show_digit=1, active_src=1 for 8 cycles. Then show_digit=0 for 2 cycles, busy=0.
- rd_req(3) and wr_req(7) in the same cycle -> wr shown first (digit=7, wr_ack), then after 8+2 cycles rd shown (digit=3, rd_ack). Exactly one ack each.
- Show rd(4), then err_req(9) at cycle 3 of SHOW -> err_ack 2 cycles later, digit=9, active_src=3, error_flag=1 and sticky. Full 8-cycle hold, no blank before it, rd message not re-shown.
- Three rd_req pulses (1, 2, 6) while a wr message is showing -> only rd_digit=6 displayed afterwards, one rd_ack.
- init_done=1 -> init_ok=1 one cycle later. After an error message: init_ok=0, error_flag=1 until rst. rst asserted in SHOW -> next cycle all outputs 0.
- BLANK_CYCLES=0 with wr and rd both pending -> rd starts the cycle after wr's 8-cycle hold ends (plus 1 IDLE cycle), never a dash gap.
